my_shift_reg: RTL

- Parametrised multi-bit shift register built as the next generation of the single-bit master/slave flip-flop.
- Generalises width and depth, and adds asynchronous reset, hold, bidirectional shift, parallel load, an optional rotate mode and a shift counter with a done flag.
- Used as a serialiser/deserialiser and delay line in the switch-level test designs and their benches.

---
 rtl/my_shift_reg.sv | 80 ++++++++
 1 files changed

// File: rtl/my_shift_reg.sv
// Parametrised multi-stage shift register: hold, shift up/down, parallel load,
// optional end-stage recirculation, and a saturating shift counter with done flag.
module my_shift_reg #(
  parameter int WIDTH  = 4,
  parameter int DEPTH  = 4,
  parameter int ROTATE = 0,
  parameter int CW     = 3
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [1:0]               mode,
  input  logic [WIDTH-1:0]         sin,
  input  logic [WIDTH*DEPTH-1:0]   pdata,
  output logic [WIDTH*DEPTH-1:0]   pout,
  output logic [WIDTH-1:0]         sout_up,
  output logic [WIDTH-1:0]         sout_dn,
  output logic [CW-1:0]            shift_cnt,
  output logic                     done
);

  localparam int PW = WIDTH * DEPTH;
  localparam logic [CW-1:0] CNT_MAX = CW'(DEPTH);

  localparam logic [1:0] MODE_UP   = 2'b01;
  localparam logic [1:0] MODE_DN   = 2'b10;
  localparam logic [1:0] MODE_LOAD = 2'b11;

  logic [PW-1:0]    data_q, data_d;
  logic [CW-1:0]    cnt_q, cnt_d, cnt_inc;
  logic             done_q;
  logic [WIDTH-1:0] up_in, dn_in;

  // Stage i lives in data_q[i*WIDTH +: WIDTH]; stage 0 is the low slice.
  assign sout_up   = data_q[PW-1 -: WIDTH];
  assign sout_dn   = data_q[WIDTH-1:0];
  assign pout      = data_q;
  assign shift_cnt = cnt_q;
  assign done      = done_q;

  assign up_in   = (ROTATE != 0) ? sout_up : sin;
  assign dn_in   = (ROTATE != 0) ? sout_dn : sin;
  assign cnt_inc = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;

  // Any mode value outside the three active encodings (including X) holds.
  always_comb begin
    data_d = data_q;
    cnt_d  = cnt_q;
    case (mode)
      MODE_UP: begin
        data_d = {data_q[PW-WIDTH-1:0], up_in};
        cnt_d  = cnt_inc;
      end
      MODE_DN: begin
        data_d = {dn_in, data_q[PW-1:WIDTH]};
        cnt_d  = cnt_inc;
      end
      MODE_LOAD: begin
        data_d = pdata;
        cnt_d  = '0;
      end
      default: begin
        data_d = data_q;
        cnt_d  = cnt_q;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q <= '0;
      cnt_q  <= '0;
      done_q <= 1'b0;
    end else begin
      data_q <= data_d;
      cnt_q  <= cnt_d;
      done_q <= (cnt_d == CNT_MAX);
    end
  end

endmodule
